// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the six-digit seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  // Everything off on the active-low buses.
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [5:0] SEL_OFF = 6'h3F;

  // Active-low {dp,g,f,e,d,c,b,a} codes for hex digits 0..F, dp bit unlit.
  localparam logic [7:0] SEG_CODES [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Digit index after i, wrapping from the leftmost digit back to 0.
  function automatic logic [2:0] next_digit(input logic [2:0] i);
    return (i == 3'(NUM_DIGITS - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  // True when nibbles i..5 of d are all zero (digit i is a leading zero).
  function automatic logic lead_zero(input logic [23:0] d, input logic [2:0] i);
    logic r;
    r = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(i)) && (d[k*4 +: 4] != 4'd0)) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble plus decimal point to active-low segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Table lookup; a lit dp pulls bit 7 low.
  always_comb begin
    seg = SEG_CODES[nibble] & {~dp, 7'h7F};
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 6-digit multiplexed seven-segment display.
// Time-slices the shared segment bus between six active-low digit enables,
// inserts a blanking gap after each digit, and swaps in newly loaded display
// content only at frame boundaries so a frame never shows mixed values.
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank leading zero digits
// (digit 0 always shown, a lit dp on a blanked digit still shown).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIVCLK_CNTMAX = 24999,
  parameter int ON_TICKS      = 4,
  parameter int BLANK_TICKS   = 1
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] disp_data,
  input  logic [5:0]  dp_mask,
  input  logic        load,
  output logic        load_ack,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led,
  output logic        frame_done
);

  localparam int             CW         = (DIVCLK_CNTMAX > 0) ? $clog2(DIVCLK_CNTMAX + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(DIVCLK_CNTMAX);
  localparam logic [3:0]     ON_LAST    = 4'(ON_TICKS - 1);
  localparam logic [3:0]     BLANK_LAST = 4'(BLANK_TICKS - 1);
  localparam logic [2:0]     LAST_IDX   = 3'(NUM_DIGITS - 1);

  state_t        state, state_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt;
  logic [3:0]    tick_cnt, tcnt_n;
  logic          tick;
  logic          last_slot;
  logic          enter0;

  logic [23:0]   shadow_data, shadow_data_n, pend_data;
  logic [5:0]    shadow_dp, shadow_dp_n, pend_dp;
  logic          pending;

  logic [3:0]    nib_n;
  logic          dp_n;
  logic [7:0]    dec_seg;
  logic [7:0]    led_on;

  assign tick = (state != IDLE) && (cnt == CNT_LAST);

  // Next state, digit index and per-phase tick count; flags the end of digit 5's slot.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    tcnt_n    = tick_cnt;
    last_slot = 1'b0;
    if (!en) begin
      state_n = IDLE;
      idx_n   = 3'd0;
      tcnt_n  = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ON;
          idx_n   = 3'd0;
          tcnt_n  = 4'd0;
        end
        ON: begin
          if (tick) begin
            if (tick_cnt == ON_LAST) begin
              tcnt_n = 4'd0;
              if (BLANK_TICKS == 0) begin
                idx_n     = next_digit(idx);
                last_slot = (idx == LAST_IDX);
              end else begin
                state_n = BLANK;
              end
            end else begin
              tcnt_n = tick_cnt + 4'd1;
            end
          end
        end
        BLANK: begin
          if (tick) begin
            if (tick_cnt == BLANK_LAST) begin
              tcnt_n    = 4'd0;
              state_n   = ON;
              idx_n     = next_digit(idx);
              last_slot = (idx == LAST_IDX);
            end else begin
              tcnt_n = tick_cnt + 4'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Frame boundary: the edge that enters digit 0's ON; the shadow view is what that edge will show.
  always_comb begin
    enter0        = (state_n == ON) && (idx_n == 3'd0) && ((state == IDLE) || last_slot);
    shadow_data_n = (enter0 && pending) ? pend_data : shadow_data;
    shadow_dp_n   = (enter0 && pending) ? pend_dp   : shadow_dp;
    nib_n         = shadow_data_n[{idx_n, 2'b00} +: 4];
    dp_n          = shadow_dp_n[idx_n];
  end

  seg_hex_decode u_dec (
    .nibble (nib_n),
    .dp     (dp_n),
    .seg    (dec_seg)
  );

  // Segment pattern for the digit about to be driven, with optional leading-zero suppression.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_n != 3'd0) && lead_zero(shadow_data_n, idx_n)) begin
      led_on = dp_n ? 8'h7F : SEG_OFF;
    end else begin
      led_on = dec_seg;
    end
`else
    led_on = dec_seg;
`endif
  end

  // State, digit index, prescaler and phase tick counter.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cnt      <= '0;
      tick_cnt <= 4'd0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      tick_cnt <= tcnt_n;
      if ((state == IDLE) || (state_n == IDLE) || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pending buffer (last load wins) and shadow register updated only at frame boundaries.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= 24'd0;
      shadow_dp   <= 6'd0;
      pend_data   <= 24'd0;
      pend_dp     <= 6'd0;
      pending     <= 1'b0;
    end else begin
      shadow_data <= shadow_data_n;
      shadow_dp   <= shadow_dp_n;
      if (load) begin
        pend_data <= disp_data;
        pend_dp   <= dp_mask;
        pending   <= 1'b1;
      end else if (enter0) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered pin outputs, aligned with the state and index registers.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      seg_sel    <= SEL_OFF;
      seg_led    <= SEG_OFF;
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      if (state_n == ON) begin
        seg_sel <= ~(6'b000001 << idx_n);
        seg_led <= led_on;
      end else begin
        seg_sel <= SEL_OFF;
        seg_led <= SEG_OFF;
      end
      frame_done <= last_slot;
      load_ack   <= enter0 && pending;
    end
  end

endmodule
